// File: rtl/mmio_led_ctrl_pkg.sv
// Shared definitions for the memory-mapped LED controller: register word
// offsets and the default bus window.
package mmio_pkg;

  typedef enum logic [2:0] {
    REG_OUT    = 3'd0,
    REG_SET    = 3'd1,
    REG_CLR    = 3'd2,
    REG_MASK   = 3'd3,
    REG_PERIOD = 3'd4,
    REG_STATUS = 3'd5
  } reg_idx_e;

  localparam int unsigned REG_COUNT     = 6;
  localparam logic [31:0] LED_BASE_ADDR = 32'h0000_0008;

endpackage

// File: rtl/mmio_led_ctrl_if.sv
// Core data-bus slice seen by the LED controller: one access per cycle with
// registered read data and window-hit flag.
interface mmio_led_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        write;
  logic [31:0] rdata;
  logic        hit;

  modport master (output addr, output wdata, output write, input rdata, input hit);
  modport slave  (input addr, input wdata, input write, output rdata, output hit);
endinterface

// File: rtl/mmio_led_ctrl_blink_timer.sv
// Blink engine: counts 0..period-1 and toggles the phase on each wrap; a load
// restarts both. phase_next exposes the value the phase takes at the next edge.
module blink_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  output logic                phase,
  output logic                phase_next,
  output logic [PERIOD_W-1:0] count
);

  logic [PERIOD_W-1:0] count_q, count_d;
  logic                phase_q, phase_d;

  // Next counter/phase; a load beats a wrap occurring in the same cycle.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (load || (period == {PERIOD_W{1'b0}})) begin
      count_d = {PERIOD_W{1'b0}};
      phase_d = 1'b0;
    end else if (count_q == (period - PERIOD_W'(1))) begin
      count_d = {PERIOD_W{1'b0}};
      phase_d = ~phase_q;
    end else begin
      count_d = count_q + PERIOD_W'(1);
      phase_d = phase_q;
    end
  end

  // Counter and phase state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {PERIOD_W{1'b0}};
      phase_q <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign phase      = phase_q;
  assign phase_next = phase_d;
  assign count      = count_q;

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED/GPIO output block: decodes its own word window, provides
// OUT/SET/CLR/MASK/PERIOD/STATUS registers and a hardware blink engine.
module mmio_led_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned N_CH         = 6,
  parameter logic [31:0] BASE_ADDR    = LED_BASE_ADDR,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned PERIOD_W     = 24,
  parameter int unsigned RESET_PERIOD = 0
) (
  input  logic            clk,
  input  logic            rst,
  mmio_led_ctrl_if.slave  bus,
  output logic [N_CH-1:0] led_out,
  output logic            blink_phase
);

  logic [29:0]         word_s;
  logic                in_win_s;
  reg_idx_e            idx_s;
  logic                we_s;
  logic                load_s;
  logic                phase_s;
  logic                phase_next_s;
  logic [PERIOD_W-1:0] count_s;

  logic [N_CH-1:0]     out_q, out_d;
  logic [N_CH-1:0]     mask_q, mask_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                hit_q;
  logic [N_CH-1:0]     led_q, led_d;

  // Unsigned subtraction wraps below the base, so the >= test is still needed.
  assign word_s   = 30'((bus.addr - BASE_ADDR) >> 2);
  assign in_win_s = (bus.addr >= BASE_ADDR) && (word_s <= 30'(REG_COUNT - 1));
  assign idx_s    = reg_idx_e'(word_s[2:0]);
  assign we_s     = bus.write && in_win_s;

  blink_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .period     (period_q),
    .load       (load_s),
    .phase      (phase_s),
    .phase_next (phase_next_s),
    .count      (count_s)
  );

  // Register write decode.
  always_comb begin
    out_d    = out_q;
    mask_d   = mask_q;
    period_d = period_q;
    load_s   = 1'b0;
    if (we_s) begin
      case (idx_s)
        REG_OUT:    out_d  = bus.wdata[N_CH-1:0];
        REG_SET:    out_d  = out_q | bus.wdata[N_CH-1:0];
        REG_CLR:    out_d  = out_q & ~bus.wdata[N_CH-1:0];
        REG_MASK:   mask_d = bus.wdata[N_CH-1:0];
        REG_PERIOD: begin
          period_d = bus.wdata[PERIOD_W-1:0];
          load_s   = 1'b1;
        end
        default:    load_s = 1'b0;
      endcase
    end else begin
      load_s = 1'b0;
    end
  end

  // Read mux from pre-write register values.
  always_comb begin
    rdata_d = 32'd0;
    if (in_win_s) begin
      case (idx_s)
        REG_OUT:    rdata_d = 32'(out_q);
        REG_MASK:   rdata_d = 32'(mask_q);
        REG_PERIOD: rdata_d = 32'(period_q);
        REG_STATUS: rdata_d = 32'({count_s, phase_s});
        default:    rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // Blink uses the phase after this edge so led_out stays aligned with blink_phase.
  assign led_d = (out_q ^ (mask_q & {N_CH{phase_next_s}})) ^ {N_CH{ACTIVE_LOW}};

  // Register file and registered bus/LED outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= {N_CH{1'b0}};
      mask_q   <= {N_CH{1'b0}};
      period_q <= PERIOD_W'(RESET_PERIOD);
      rdata_q  <= 32'd0;
      hit_q    <= 1'b0;
      led_q    <= {N_CH{ACTIVE_LOW}};
    end else begin
      out_q    <= out_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      rdata_q  <= rdata_d;
      hit_q    <= in_win_s;
      led_q    <= led_d;
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.hit     = hit_q;
  assign led_out     = led_q;
  assign blink_phase = phase_s;

endmodule
